// File: rtl/mem_sys_pkg.sv
// Shared definitions for the memory-system arbiter: requester indices, arbiter FSM states,
// default line/address widths and the round-robin pointer update helper.
package mem_sys_pkg;

  localparam int unsigned CL_SIZE_DEFAULT = 128;
  localparam int unsigned ADDR_W_DEFAULT  = 32;

  // Requester count is fixed: one D$ port and two I$ bank ports.
  localparam int unsigned N_REQ       = 3;
  localparam int unsigned REQ_DC      = 0;
  localparam int unsigned REQ_IC_EVEN = 1;
  localparam int unsigned REQ_IC_ODD  = 2;

  localparam int unsigned PTR_W = 2;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } arb_state_e;

  // Highest-priority index after a grant: the requester just behind the winner.
  function automatic logic [PTR_W-1:0] rr_next_ptr(input logic [N_REQ-1:0] winner);
    logic [PTR_W-1:0] nxt;
    unique case (winner)
      3'b001:  nxt = 2'd1;
      3'b010:  nxt = 2'd2;
      3'b100:  nxt = 2'd0;
      default: nxt = 2'd0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the line-request arbiter.
// master: the arbiter's view. slave: the requesters plus backing memory.
interface mem_req_arbiter_if
  import mem_sys_pkg::*;
#(
  parameter int unsigned CL_SIZE = CL_SIZE_DEFAULT,
  parameter int unsigned ADDR_W  = ADDR_W_DEFAULT
);

  // Requester side
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        req_is_write;
  logic [CL_SIZE-1:0]      req_wdata;
  logic [N_REQ-1:0]        grant;
  logic [N_REQ-1:0]        resp_valid;
  logic [CL_SIZE-1:0]      resp_data;

  // Memory side
  logic                    mem_req_valid;
  logic                    mem_ready;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_is_write;
  logic [CL_SIZE-1:0]      mem_wdata;
  logic                    mem_resp_valid;
  logic [CL_SIZE-1:0]      mem_resp_data;

  logic                    arb_busy;

  modport master (
    input  req, req_addr, req_is_write, req_wdata,
    input  mem_ready, mem_resp_valid, mem_resp_data,
    output grant, resp_valid, resp_data,
    output mem_req_valid, mem_addr, mem_is_write, mem_wdata,
    output arb_busy
  );

  modport slave (
    output req, req_addr, req_is_write, req_wdata,
    output mem_ready, mem_resp_valid, mem_resp_data,
    input  grant, resp_valid, resp_data,
    input  mem_req_valid, mem_addr, mem_is_write, mem_wdata,
    input  arb_busy
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the memory-port arbiter.
// MEM_ARB_RR_EN defined  : round-robin search starting at ptr_i.
// MEM_ARB_RR_EN undefined: fixed priority D$ > I$ even > I$ odd, no pointer input.
module mem_arb_pick
  import mem_sys_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
`ifdef MEM_ARB_RR_EN
  input  logic [PTR_W-1:0] ptr_i,
`endif
  output logic [N_REQ-1:0] gnt_o
);

`ifdef MEM_ARB_RR_EN
  logic [PTR_W-1:0] idx;

  // First requesting index in the order ptr, ptr+1, ptr+2 (mod 3) wins.
  always_comb begin
    gnt_o = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PTR_W'((int'(ptr_i) + k) % N_REQ);
      if (gnt_o == '0 && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
      end
    end
  end
`else
  // Fixed priority: lowest index wins.
  always_comb begin
    gnt_o = '0;
    if (req_i[REQ_DC]) begin
      gnt_o[REQ_DC] = 1'b1;
    end else if (req_i[REQ_IC_EVEN]) begin
      gnt_o[REQ_IC_EVEN] = 1'b1;
    end else if (req_i[REQ_IC_ODD]) begin
      gnt_o[REQ_IC_ODD] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one line-granular memory port between the D$ and the two I$ bank miss paths.
// One transaction in flight: pick in IDLE, present request in ISSUE, await response in WAIT.
// MEM_ARB_RR_EN selects round-robin arbitration (adds a pointer register); otherwise fixed
// priority.
module mem_req_arbiter
  import mem_sys_pkg::*;
#(
  parameter int unsigned CL_SIZE = CL_SIZE_DEFAULT,
  parameter int unsigned ADDR_W  = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  mem_req_arbiter_if.master bus
);

  // Byte-offset bits inside a line, forced to zero on mem_addr.
  localparam logic [ADDR_W-1:0] OffMask = ADDR_W'(CL_SIZE / 8 - 1);

  arb_state_e         state_q, state_d;
  logic [N_REQ-1:0]   pick;
  logic               pick_en;
  logic [ADDR_W-1:0]  pick_addr;

  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               is_write_q, is_write_d;
  logic [CL_SIZE-1:0] wdata_q, wdata_d;
  logic [N_REQ-1:0]   resp_valid_q, resp_valid_d;
  logic [CL_SIZE-1:0] resp_data_q, resp_data_d;

`ifdef MEM_ARB_RR_EN
  logic [PTR_W-1:0]   ptr_q, ptr_d;
`endif

  mem_arb_pick u_pick (
    .req_i (bus.req),
`ifdef MEM_ARB_RR_EN
    .ptr_i (ptr_q),
`endif
    .gnt_o (pick)
  );

  // No pick during the response-pulse cycle: the finishing requester still holds req there.
  assign pick_en = (state_q == ARB_IDLE) && (resp_valid_q == '0) && (|bus.req);

  // One-hot mux of the winner's address slice.
  always_comb begin
    pick_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[i]) begin
        pick_addr = pick_addr | bus.req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:  if (pick_en)            state_d = ARB_ISSUE;
      ARB_ISSUE: if (bus.mem_ready)      state_d = ARB_WAIT;
      ARB_WAIT:  if (bus.mem_resp_valid) state_d = ARB_IDLE;
      default:                           state_d = ARB_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.mem_req_valid = 1'b0;
    bus.arb_busy      = 1'b0;
    unique case (state_q)
      ARB_IDLE:  ;
      ARB_ISSUE: begin
        bus.mem_req_valid = 1'b1;
        bus.arb_busy      = 1'b1;
      end
      ARB_WAIT:  bus.arb_busy = 1'b1;
      default:   ;
    endcase
  end

  // Payload latch, grant tracking and response capture.
  always_comb begin
    grant_d      = grant_q;
    addr_d       = addr_q;
    is_write_d   = is_write_q;
    wdata_d      = wdata_q;
    resp_valid_d = '0;
    resp_data_d  = '0;
    // Grant is held through the pulse cycle and dropped after it.
    if (resp_valid_q != '0) begin
      grant_d = '0;
    end
    if (pick_en) begin
      grant_d    = pick;
      addr_d     = pick_addr & ~OffMask;
      // Only the D$ issues writebacks; I$ write flags are ignored.
      is_write_d = pick[REQ_DC] & (|(pick & bus.req_is_write));
      wdata_d    = bus.req_wdata;
    end
    if (state_q == ARB_WAIT && bus.mem_resp_valid) begin
      resp_valid_d = grant_q;
      resp_data_d  = is_write_q ? '0 : bus.mem_resp_data;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q      <= '0;
      addr_q       <= '0;
      is_write_q   <= 1'b0;
      wdata_q      <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      is_write_q   <= is_write_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Round-robin pointer moves past each winner.
  always_comb begin
    ptr_d = ptr_q;
    if (pick_en) begin
      ptr_d = rr_next_ptr(pick);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign bus.grant        = grant_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_data    = resp_data_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_is_write = is_write_q;
  assign bus.mem_wdata    = wdata_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized self-checking bench for mem_req_arbiter against a transaction-level model:
// winner chosen by searching from a priority index, payload snapshotted at grant time,
// response timing derived from the documented latencies.
module tb_mem_req_arbiter;

  localparam int unsigned CL_SIZE = 128;
  localparam int unsigned ADDR_W  = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_req_arbiter_if #(.CL_SIZE(CL_SIZE), .ADDR_W(ADDR_W)) bus ();

  mem_req_arbiter #(.CL_SIZE(CL_SIZE), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Model state: outstanding requests and the current highest-priority index.
  logic [2:0] req_r;
  int         ref_ptr;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // First requester found searching p, p+1, p+2 (mod 3); p stays 0 for fixed priority.
  function automatic int ref_pick(input logic [2:0] r, input int p);
    int res;
    res = -1;
    for (int k = 0; k < 3; k++) begin
      if (res < 0 && r[(p + k) % 3]) res = (p + k) % 3;
    end
    return res;
  endfunction

  task automatic scramble_payload();
    bus.req_addr     = {$urandom, $urandom, $urandom};
    bus.req_wdata    = rand128();
    bus.req_is_write = 3'($urandom);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_grant"}, 128'(bus.grant), 128'(0));
    check_eq({tag, "_resp_valid"}, 128'(bus.resp_valid), 128'(0));
    check_eq({tag, "_mem_req_valid"}, 128'(bus.mem_req_valid), 128'(0));
    check_eq({tag, "_busy"}, 128'(bus.arb_busy), 128'(0));
  endtask

  // Entered at a negedge of an idle cycle with req_r != 0 already driven.
  task automatic run_txn(input int stall, input bit junk_resp, input int dly, input bit drop,
                         input logic [2:0] new_req, input bit rst_wait,
                         input logic [127:0] rdata, output logic [2:0] got_gnt);
    int           w;
    logic [2:0]   wb;
    logic [31:0]  e_addr;
    logic         e_wr;
    logic [127:0] e_wdata;
    w       = ref_pick(req_r, ref_ptr);
    wb      = 3'(1 << w);
    e_addr  = bus.req_addr[w*32 +: 32] & ~32'hF;
    e_wr    = (w == 0) && bus.req_is_write[0];
    e_wdata = bus.req_wdata;
`ifdef MEM_ARB_RR_EN
    ref_ptr = (w + 1) % 3;
`endif
    @(negedge clk);
    got_gnt = bus.grant;
    check_eq("grant", 128'(bus.grant), 128'(wb));
    check_eq("issue_valid", 128'(bus.mem_req_valid), 128'(1));
    check_eq("issue_busy", 128'(bus.arb_busy), 128'(1));
    check_eq("mem_addr", 128'(bus.mem_addr), 128'(e_addr));
    check_eq("mem_is_write", 128'(bus.mem_is_write), 128'(e_wr));
    if (e_wr) check_eq("mem_wdata", bus.mem_wdata, e_wdata);
    // Inputs change after grant; the in-flight payload must not.
    scramble_payload();
    if (drop) req_r[w] = 1'b0;
    bus.req = req_r;
    for (int s = 0; s < stall; s++) begin
      bus.mem_ready      = 1'b0;
      bus.mem_resp_valid = junk_resp;
      bus.mem_resp_data  = rand128();
      @(negedge clk);
      check_eq("stall_valid", 128'(bus.mem_req_valid), 128'(1));
      check_eq("stall_addr", 128'(bus.mem_addr), 128'(e_addr));
      check_eq("stall_is_write", 128'(bus.mem_is_write), 128'(e_wr));
      check_eq("stall_resp_valid", 128'(bus.resp_valid), 128'(0));
      check_eq("stall_grant", 128'(bus.grant), 128'(wb));
    end
    bus.mem_resp_valid = 1'b0;
    bus.mem_ready      = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    check_eq("accepted_valid", 128'(bus.mem_req_valid), 128'(0));
    check_eq("wait_busy", 128'(bus.arb_busy), 128'(1));
    check_eq("wait_grant", 128'(bus.grant), 128'(wb));
    if (rst_wait) begin
      #2 rst = 1'b1;
      #1;
      check_idle("rst_async");
      check_eq("rst_mem_addr", 128'(bus.mem_addr), 128'(0));
      @(negedge clk);
      rst     = 1'b0;
      req_r   = '0;
      bus.req = '0;
      ref_ptr = 0;
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = rand128();
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      check_idle("post_rst_resp");
      return;
    end
    for (int d = 0; d < dly; d++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("wait_resp_valid", 128'(bus.resp_valid), 128'(0));
      check_eq("wait_busy2", 128'(bus.arb_busy), 128'(1));
    end
    bus.mem_ready      = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = rdata;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    check_eq("resp_valid", 128'(bus.resp_valid), 128'(wb));
    check_eq("resp_data", bus.resp_data, e_wr ? 128'(0) : rdata);
    check_eq("resp_grant", 128'(bus.grant), 128'(wb));
    check_eq("resp_busy", 128'(bus.arb_busy), 128'(0));
    req_r   = (req_r & ~wb) | new_req;
    bus.req = req_r;
    @(negedge clk);
    check_idle("bubble");
  endtask

  task automatic load_req(input logic [2:0] r);
    req_r   = r;
    bus.req = r;
  endtask

  logic [2:0] g;
  logic [2:0] t3_exp [3];

  initial begin
`ifdef MEM_ARB_RR_EN
    t3_exp = '{3'b001, 3'b010, 3'b100};
`else
    t3_exp = '{3'b001, 3'b001, 3'b001};
`endif
    rst                = 1'b1;
    ref_ptr            = 0;
    req_r              = '0;
    bus.req            = '0;
    bus.req_addr       = '0;
    bus.req_is_write   = '0;
    bus.req_wdata      = '0;
    bus.mem_ready      = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    @(negedge clk);
    check_idle("reset");
    check_eq("reset_resp_data", bus.resp_data, 128'(0));
    check_eq("reset_mem_addr", 128'(bus.mem_addr), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_reset");

    // Contention: all three held for three transactions.
    scramble_payload();
    load_req(3'b111);
    for (int k = 0; k < 3; k++) begin
      run_txn(0, 1'b0, 1, 1'b0, (k < 2) ? 3'b111 : 3'b000, 1'b0, rand128(), g);
      check_eq("contention_order", 128'(g), 128'(t3_exp[k]));
    end
    for (int k = 0; k < 3; k++) begin
      if (req_r != '0) run_txn(0, 1'b0, 0, 1'b0, 3'b000, 1'b0, rand128(), g);
    end

    // Single read from I$ even bank.
    scramble_payload();
    bus.req_addr[32 +: 32] = 32'h40;
    load_req(3'b010);
    run_txn(0, 1'b0, 2, 1'b0, 3'b000, 1'b0, {16{8'hA5}}, g);

    // D$ writeback with unaligned address.
    scramble_payload();
    bus.req_addr[0 +: 32] = 32'h62;
    bus.req_is_write      = 3'b001;
    bus.req_wdata         = 128'hDEADBEEF;
    load_req(3'b001);
    run_txn(0, 1'b0, 1, 1'b0, 3'b000, 1'b0, rand128(), g);

    // Long mem_ready stall with stray responses during ISSUE.
    scramble_payload();
    load_req(3'b100);
    run_txn(5, 1'b1, 1, 1'b0, 3'b000, 1'b0, rand128(), g);

    // Requester drops req right after grant.
    scramble_payload();
    load_req(3'b010);
    run_txn(1, 1'b0, 1, 1'b1, 3'b000, 1'b0, rand128(), g);

    // Reset while waiting for memory, then normal operation resumes.
    scramble_payload();
    load_req(3'b011);
    run_txn(1, 1'b0, 0, 1'b0, 3'b000, 1'b1, rand128(), g);
    scramble_payload();
    load_req(3'b100);
    run_txn(0, 1'b0, 0, 1'b0, 3'b000, 1'b0, rand128(), g);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      if (req_r == '0) load_req(3'($urandom_range(1, 7)));
      run_txn(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 3) == 0), 3'($urandom), 1'b0, rand128(), g);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
